// File: rtl/pipeline_muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Optional early-out multiply enabled by defining MULDIV_EARLY_OUT_EN.
module pipeline_muldiv #(
    parameter int XLEN      = 32,
    parameter int STEP_BITS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            cancel,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi_out,
    output logic [XLEN-1:0] lo_out,
    output logic            bad_op
);
    localparam int N  = XLEN / STEP_BITS;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic              is_div;
    logic              neg_q;
    logic              neg_r;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   opb;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    logic              done_q;
    logic              bad_q;

    logic              accept;
    logic              signed_op;
    logic              sgn_a;
    logic              sgn_b;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;

    assign req_ready = (state == S_IDLE) && !rst;
    assign accept    = req_valid && req_ready && !cancel;
    assign busy      = (state != S_IDLE);
    assign done      = done_q;
    assign bad_op    = bad_q;
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;

    assign signed_op = (req_op == 3'd0) || (req_op == 3'd2);
    assign sgn_a     = signed_op && req_a[XLEN-1];
    assign sgn_b     = signed_op && req_b[XLEN-1];
    assign abs_a     = sgn_a ? -req_a : req_a;
    assign abs_b     = sgn_b ? -req_b : req_b;

    // One RUN edge: STEP_BITS shift-add or restoring-divide iterations.
    // For divide, acc holds {remainder, dividend/quotient}.
    logic [2*XLEN-1:0] acc_nx;
    logic [2*XLEN-1:0] mcand_nx;
    logic [XLEN-1:0]   opb_nx;
    logic [XLEN:0]     rem;
    logic [XLEN:0]     diff;

    always_comb begin
        acc_nx   = acc;
        mcand_nx = mcand;
        opb_nx   = opb;
        rem      = '0;
        diff     = '0;
        if (is_div) begin
            for (int i = 0; i < STEP_BITS; i++) begin
                rem    = {acc_nx[2*XLEN-1:XLEN], acc_nx[XLEN-1]};
                diff   = rem - {1'b0, opb};
                acc_nx = acc_nx << 1;
                if (rem >= {1'b0, opb}) begin
                    acc_nx[2*XLEN-1:XLEN] = diff[XLEN-1:0];
                    acc_nx[0]             = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < STEP_BITS; i++) begin
                if (opb_nx[0]) begin
                    acc_nx = acc_nx + mcand_nx;
                end
                mcand_nx = mcand_nx << 1;
                opb_nx   = opb_nx >> 1;
            end
        end
    end

    logic go_fix;
    assign go_fix = (cnt == '0) ||
                    (EARLY_OUT && !is_div && (opb_nx == '0));

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   q_fix;
    logic [XLEN-1:0]   r_fix;

    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        q_fix    = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        r_fix    = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            opb    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            bad_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            bad_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (req_op)
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                is_div <= req_op[1];
                                neg_q  <= sgn_a ^ sgn_b;
                                neg_r  <= sgn_a;
                                cnt    <= CW'(N - 1);
                                opb    <= abs_b;
                                state  <= S_RUN;
                                if (req_op[1]) begin
                                    acc   <= {{XLEN{1'b0}}, abs_a};
                                    mcand <= '0;
                                end else begin
                                    acc   <= '0;
                                    mcand <= {{XLEN{1'b0}}, abs_a};
                                end
                            end
                            3'd4:    hi_q  <= req_a;
                            3'd5:    lo_q  <= req_a;
                            default: bad_q <= 1'b1;
                        endcase
                    end
                end
                S_RUN: begin
                    if (cancel) begin
                        state <= S_IDLE;
                    end else begin
                        acc   <= acc_nx;
                        mcand <= mcand_nx;
                        opb   <= opb_nx;
                        cnt   <= cnt - 1'b1;
                        if (go_fix) begin
                            state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    state <= S_IDLE;
                    if (!cancel) begin
                        done_q <= 1'b1;
                        if (is_div) begin
                            hi_q <= r_fix;
                            lo_q <= q_fix;
                        end else begin
                            hi_q <= prod_fix[2*XLEN-1:XLEN];
                            lo_q <= prod_fix[XLEN-1:0];
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
